fc_layer_ctrl: RTL and testbench

Sequencer for one fully-connected layer. It sits between an input `double_fifo` bank and an `fc_layer` MAC datapath. When a full input bank is presented, it walks every output neuron, issuing weight, input and bias addresses plus MAC control strobes. It hands each neuron result to the downstream stage over a valid/ready handshake, then releases the input bank with a one-cycle `yumi_o` pulse.

---
 rtl/fc_layer_ctrl.sv | 154 +++++++++++++++
 tb/tb_fc_layer_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequencer for one fully-connected layer.
// Walks every output neuron of the layer. For each neuron it clears the
// accumulator, streams the IN weight/input addresses, and adds the bias.
// It then presents the result over a valid/ready handshake. After the last
// neuron is accepted it pulses yumi_o once, which releases the input bank.
module fc_layer_ctrl #(
  parameter int INPUT_LAYER_HEIGHT  = 4,
  parameter int OUTPUT_LAYER_HEIGHT = 3,
  localparam int IW = $clog2(INPUT_LAYER_HEIGHT),
  localparam int WW = $clog2(INPUT_LAYER_HEIGHT * OUTPUT_LAYER_HEIGHT),
  localparam int NW = (OUTPUT_LAYER_HEIGHT > 1) ? $clog2(OUTPUT_LAYER_HEIGHT) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          valid_i,
  output logic          yumi_o,
  output logic [IW-1:0] in_addr_o,
  output logic [WW-1:0] weight_addr_o,
  output logic [NW-1:0] bias_addr_o,
  output logic          mac_clear_o,
  output logic          mac_en_o,
  output logic          bias_en_o,
  output logic [NW-1:0] neuron_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MAC     = 3'd2,
    S_BIAS    = 3'd3,
    S_WAIT    = 3'd4,
    S_OUT     = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  // Terminal counts: counters wrap on explicit compare, so non-power-of-2
  // sizes never produce out-of-range addresses.
  localparam logic [IW-1:0] K_LAST = IW'(INPUT_LAYER_HEIGHT - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_LAYER_HEIGHT - 1);
  localparam logic [WW-1:0] W_STEP = WW'(INPUT_LAYER_HEIGHT);

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [IW-1:0] k_q, k_d;
  // Running n*IN, so the weight address needs only an adder, not a multiplier.
  logic [WW-1:0] wbase_q, wbase_d;
  logic          mac_en_q;

  // State and counter registers. mac_en_q is MAC state delayed by one
  // cycle, which matches the 1-cycle read latency of the memories.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      wbase_q  <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      wbase_q  <= wbase_d;
      mac_en_q <= (state_q == S_MAC);
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    wbase_d = wbase_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_CLEAR;
          n_d     = '0;
          wbase_d = '0;
        end
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_BIAS;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_BIAS: state_d = S_WAIT;
      S_WAIT: state_d = S_OUT;
      S_OUT: begin
        if (ready_i) begin
          if (n_q == N_LAST) begin
            state_d = S_RELEASE;
          end else begin
            n_d     = n_q + NW'(1);
            wbase_d = wbase_q + W_STEP;
            state_d = S_CLEAR;
          end
        end
      end
      S_RELEASE: begin
        // Return to idle with the neuron index parked at zero.
        state_d = S_IDLE;
        n_d     = '0;
        wbase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        n_d     = '0;
        k_d     = '0;
        wbase_d = '0;
      end
    endcase
  end

  // Output decode from registered state only; ready_i/valid_i never reach outputs.
  always_comb begin
    yumi_o        = 1'b0;
    in_addr_o     = '0;
    weight_addr_o = '0;
    bias_addr_o   = '0;
    mac_clear_o   = 1'b0;
    bias_en_o     = 1'b0;
    valid_o       = 1'b0;
    last_o        = 1'b0;
    neuron_o      = n_q;
    mac_en_o      = mac_en_q;
    case (state_q)
      S_CLEAR: mac_clear_o = 1'b1;
      S_MAC: begin
        in_addr_o     = k_q;
        weight_addr_o = wbase_q + WW'(k_q);
      end
      S_BIAS: bias_addr_o = n_q;
      S_WAIT: bias_en_o = 1'b1;
      S_OUT: begin
        valid_o = 1'b1;
        last_o  = (n_q == N_LAST);
      end
      S_RELEASE: yumi_o = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: table-driven, hand-sequenced and randomized checks of
// fc_layer_ctrl against a schedule-level reference model.
module tb_fc_layer_ctrl;

  localparam int IN_A  = 4;
  localparam int OUT_A = 3;
  localparam int IN_B  = 3;
  localparam int OUT_B = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: IN=4, OUT=3
  logic       rst_a, valid_a, ready_a;
  logic       yumi_a, clr_a, men_a, ben_a, vo_a, last_a;
  logic [1:0] iaddr_a, baddr_a, neu_a;
  logic [3:0] waddr_a;

  // Instance B: IN=3, OUT=5
  logic       rst_b, valid_b, ready_b;
  logic       yumi_b, clr_b, men_b, ben_b, vo_b, last_b;
  logic [1:0] iaddr_b;
  logic [2:0] baddr_b, neu_b;
  logic [3:0] waddr_b;

  fc_layer_ctrl #(.INPUT_LAYER_HEIGHT(IN_A), .OUTPUT_LAYER_HEIGHT(OUT_A)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .valid_i(valid_a), .yumi_o(yumi_a),
    .in_addr_o(iaddr_a), .weight_addr_o(waddr_a), .bias_addr_o(baddr_a),
    .mac_clear_o(clr_a), .mac_en_o(men_a), .bias_en_o(ben_a),
    .neuron_o(neu_a), .valid_o(vo_a), .ready_i(ready_a), .last_o(last_a)
  );

  fc_layer_ctrl #(.INPUT_LAYER_HEIGHT(IN_B), .OUTPUT_LAYER_HEIGHT(OUT_B)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .valid_i(valid_b), .yumi_o(yumi_b),
    .in_addr_o(iaddr_b), .weight_addr_o(waddr_b), .bias_addr_o(baddr_b),
    .mac_clear_o(clr_b), .mac_en_o(men_b), .bias_en_o(ben_b),
    .neuron_o(neu_b), .valid_o(vo_b), .ready_i(ready_b), .last_o(last_b)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Reference model for instance A: layer progress as a position p within
  // the current neuron's slot (0 clear, 1..IN mac, IN+1 bias, IN+2 wait,
  // IN+3 result), plus idle / releasing modes.
  int m_mode = 0;  // 0 idle, 1 busy, 2 releasing
  int m_p    = 0;
  int m_n    = 0;
  bit m_prev_mac = 1'b0;

  task automatic model_adv(input bit r, input bit v, input bit rdy);
    bit mac_now;
    if (r) begin
      m_mode = 0; m_p = 0; m_n = 0; m_prev_mac = 1'b0;
      return;
    end
    mac_now = (m_mode == 1) && (m_p >= 1) && (m_p <= IN_A);
    case (m_mode)
      0: if (v) begin m_mode = 1; m_p = 0; m_n = 0; end
      1: begin
        if (m_p < IN_A + 3) m_p++;
        else if (rdy) begin
          if (m_n == OUT_A - 1) m_mode = 2;
          else begin m_n++; m_p = 0; end
        end
      end
      default: begin m_mode = 0; m_n = 0; end
    endcase
    m_prev_mac = mac_now;
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
  endtask

  task automatic check_a(input string name, input bit clr, input bit men,
                         input bit ben, input bit vo, input bit last,
                         input bit yumi, input int ia, input int wa,
                         input int ba, input int ne);
    logic [15:0] e, a;
    e = {yumi, clr, men, ben, vo, last, 2'(ia), 4'(wa), 2'(ba), 2'(ne)};
    a = {yumi_a, clr_a, men_a, ben_a, vo_a, last_a, iaddr_a, waddr_a, baddr_a, neu_a};
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h (yumi,clr,men,ben,vo,last,ia,wa,ba,n)",
                  name, cyc, a, e);
  endtask

  task automatic check_model(input string name);
    bit busy, mac, vo;
    busy = (m_mode == 1);
    mac  = busy && (m_p >= 1) && (m_p <= IN_A);
    vo   = busy && (m_p == IN_A + 3);
    check_a(name, busy && (m_p == 0), m_prev_mac, busy && (m_p == IN_A + 2), vo,
            vo && (m_n == OUT_A - 1), m_mode == 2,
            mac ? m_p - 1 : 0, mac ? m_n * IN_A + m_p - 1 : 0,
            (busy && (m_p == IN_A + 1)) ? m_n : 0, m_n);
  endtask

  task automatic tick();
    @(posedge clk);
    model_adv(rst_a, valid_a, ready_a);
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    bit v, r, clr, men, ben, vo, last, yumi;
    int ia, wa, ba, ne;
  } vec_t;

  vec_t tbl [27];

  initial begin
    int held, yc, ycnt, gap_ok, last_y, maxw, maxb, lastc, nclr;

    // Nominal layer (IN=4, OUT=3) expectations, by cycle after valid_i at 0.
    for (int c = 0; c < 27; c++) begin
      int nn, ph;
      tbl[c].v = (c == 0); tbl[c].r = 1'b1;
      tbl[c].clr = 0; tbl[c].men = 0; tbl[c].ben = 0; tbl[c].vo = 0;
      tbl[c].last = 0; tbl[c].yumi = 0;
      tbl[c].ia = 0; tbl[c].wa = 0; tbl[c].ba = 0; tbl[c].ne = 0;
      if (c >= 1 && c <= 24) begin
        nn = (c - 1) / 8; ph = (c - 1) % 8;
        tbl[c].ne  = nn;
        tbl[c].clr = (ph == 0);
        if (ph >= 1 && ph <= 4) begin tbl[c].ia = ph - 1; tbl[c].wa = nn * 4 + ph - 1; end
        tbl[c].men = (ph >= 2 && ph <= 5);
        tbl[c].ba  = (ph == 5) ? nn : 0;
        tbl[c].ben = (ph == 6);
        tbl[c].vo  = (ph == 7);
        tbl[c].last = (c == 24);
      end
      if (c == 25) begin tbl[c].yumi = 1; tbl[c].ne = 2; end
    end

    rst_a = 1; valid_a = 0; ready_a = 1;
    rst_b = 1; valid_b = 0; ready_b = 1;
    @(negedge clk);

    // Reset for 2 cycles, then 10 idle cycles: everything zero.
    tick(); tick();
    rst_a = 0;
    for (int c = 0; c < 10; c++) begin
      check_a("idle_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // Nominal layer from the table.
    for (int c = 0; c < 27; c++) begin
      valid_a = tbl[c].v; ready_a = tbl[c].r;
      check_a("nominal", tbl[c].clr, tbl[c].men, tbl[c].ben, tbl[c].vo, tbl[c].last,
              tbl[c].yumi, tbl[c].ia, tbl[c].wa, tbl[c].ba, tbl[c].ne);
      check_model("nominal_model");
      tick();
    end

    // Backpressure: ready_i low 5 cycles when neuron 1's result appears.
    held = 0; yc = -1; ycnt = 0;
    for (int c = 0; c < 33; c++) begin
      valid_a = (c == 0); ready_a = !(c >= 16 && c <= 20);
      check_model("bp_model");
      if (vo_a && neu_a == 2'd1) held++;
      if (yumi_a) begin yc = c; ycnt++; end
      tick();
    end
    chk("bp_hold", held, 6);
    chk("bp_yumi_cycle", yc, 30);
    chk("bp_yumi_count", ycnt, 1);
    ready_a = 1;

    // Reset while neuron 1 is at k=2.
    ycnt = 0;
    for (int c = 0; c < 41; c++) begin
      valid_a = (c == 0); rst_a = (c == 12);
      check_model("rst_model");
      if (c == 12) chk("pre_rst_waddr", int'(waddr_a), 6);
      if (c == 13) check_a("rst_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (yumi_a) ycnt++;
      tick();
    end
    rst_a = 0;
    chk("rst_no_yumi", ycnt, 0);
    for (int c = 0; c < 28; c++) begin
      valid_a = (c == 0);
      check_model("restart_model");
      if (c == 1) chk("restart_clear", int'(clr_a), 1);
      if (c == 2) check_a("restart_first_mac", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (c == 3) check_a("restart_second_mac", 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      tick();
    end

    // Back-to-back banks with valid_i held high.
    ycnt = 0; gap_ok = 0; last_y = -100; yc = -1;
    for (int c = 0; c < 81; c++) begin
      valid_a = (c < 56);
      check_model("b2b_model");
      if (yumi_a) begin
        if (ycnt == 0) yc = c;
        ycnt++; last_y = c;
      end
      if (clr_a && c == last_y + 2) gap_ok++;
      tick();
    end
    chk("b2b_yumi_count", ycnt, 3);
    chk("b2b_first_yumi", yc, 25);
    chk("b2b_clear_gap", gap_ok, 2);

    // Randomized traffic with occasional resets against the model.
    for (int c = 0; c < 1500; c++) begin
      rst_a   = ($urandom_range(0, 99) == 0);
      valid_a = $urandom_range(0, 1) == 1;
      ready_a = $urandom_range(0, 9) < 7;
      check_model("random_model");
      tick();
    end
    rst_a = 0; valid_a = 0; ready_a = 1;

    // Non-power-of-2 instance (IN=3, OUT=5).
    rst_b = 0;
    tick();
    maxw = 0; maxb = 0; yc = -1; ycnt = 0; lastc = -1; nclr = 0;
    for (int c = 0; c < 40; c++) begin
      valid_b = (c == 0);
      if (int'(waddr_b) > maxw) maxw = int'(waddr_b);
      if (int'(baddr_b) > maxb) maxb = int'(baddr_b);
      if (yumi_b) begin yc = c; ycnt++; end
      if (last_b) lastc = c;
      if (clr_b) nclr++;
      tick();
    end
    chk("np2_max_waddr", maxw, 14);
    chk("np2_max_baddr", maxb, 4);
    chk("np2_yumi_cycle", yc, 36);
    chk("np2_yumi_count", ycnt, 1);
    chk("np2_last_cycle", lastc, 35);
    chk("np2_clear_count", nclr, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
